// File: rtl/itcm_arbiter.sv
// itcm_arbiter: shares one single-port 16K x 32 ITCM between the CPU fetch port (M0, read-only)
// and the boot loader / debug port (M1, read/write).
// BOOT state after reset gives M1 exclusive access. RUN gives M1 priority, and a starvation
// counter forces an M0 win after STARVE_MAX lost contended cycles.
// Optional macro ITCM_ARB_OUTREG_EN: registers rvalid/rdata, so read latency becomes 2 cycles.
module itcm_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  in_boot
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       rd0_q, rd1_q;   // read issued last cycle, one tag per master

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next state, grants and starvation counter update
  always_comb begin
    state_nxt  = state;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    starve_nxt = 4'd0;
    case (state)
      BOOT: begin
        m1_gnt = m1_req;
        if (boot_done) state_nxt = RUN;
      end
      RUN: begin
        if (m0_req && m1_req) begin
          if (starve_cnt == STARVE_LIM) m0_gnt = 1'b1;
          else                          m1_gnt = 1'b1;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
        // Saturating count of consecutive cycles M0 waited
        if (m0_req && !m0_gnt)
          starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign in_boot     = (state == BOOT);
  assign ram_addr    = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);
  assign ram_wr_en   = m1_gnt & m1_we;
  assign ram_wr_data = m1_wdata;

  // Read tags: which master owns the RAM data returning next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q <= 1'b0;
      rd1_q <= 1'b0;
    end else begin
      rd0_q <= m0_gnt;
      rd1_q <= m1_gnt & ~m1_we;
    end
  end

`ifdef ITCM_ARB_OUTREG_EN
  logic                  v0_q, v1_q;
  logic [DATA_WIDTH-1:0] d_q;

  // Output register stage on read return
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d_q  <= '0;
    end else begin
      v0_q <= rd0_q;
      v1_q <= rd1_q;
      d_q  <= ram_rd_data;
    end
  end

  // rst masks rvalid so a read in flight when reset hits never reports
  assign m0_rvalid = v0_q & ~rst;
  assign m1_rvalid = v1_q & ~rst;
  assign m0_rdata  = d_q;
  assign m1_rdata  = d_q;
`else
  assign m0_rvalid = rd0_q & ~rst;
  assign m1_rvalid = rd1_q & ~rst;
  assign m0_rdata  = ram_rd_data;
  assign m1_rdata  = ram_rd_data;
`endif

endmodule

// File: tb/tb_itcm_arbiter.sv
// Directed table-driven bench for itcm_arbiter with a behavioural single-port RAM.
module tb_itcm_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
`ifdef ITCM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, boot_done;
  logic          m0_req, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic          ram_wr_en, in_boot;

  int checks = 0;
  int errors = 0;

  itcm_arbiter dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data), .in_boot(in_boot)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, read-before-write
  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) begin
    ram_rd_data <= mem[ram_addr];
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
  end

  typedef struct {
    logic          bd;
    logic          q0;
    logic [AW-1:0] a0;
    logic          q1;
    logic          we;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd;
    logic          e_boot;
    logic          e_g0;
    logic          e_g1;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t          tv [$];
  logic [DW-1:0] shadow [0:16383];
  logic          iss0 [0:63];
  logic          iss1 [0:63];
  logic [DW-1:0] issd [0:63];

  task automatic chk(input string name, input int row, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic bd, input logic q0, input logic [AW-1:0] a0,
                     input logic q1, input logic we, input logic [AW-1:0] a1,
                     input logic [DW-1:0] wd, input logic eb, input logic e0,
                     input logic e1, input logic [AW-1:0] ea);
    tv.push_back(vec_t'{bd, q0, a0, q1, we, a1, wd, eb, e0, e1, ea});
  endtask

  initial begin
    rst = 1'b1; boot_done = 1'b0;
    m0_req = 1'b1; m0_addr = 14'h0010;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    //   bd q0 a0       q1 we a1       wd            boot g0 g1 addr
    add(0, 1, 14'h0010, 1, 1, 14'h0010, 32'hDEADBEEF, 1, 0, 1, 14'h0010); // BOOT write, M0 blocked
    add(0, 1, 14'h0010, 0, 0, 14'h0000, 32'h0,        1, 0, 0, 14'h0000);
    add(0, 1, 14'h0010, 1, 0, 14'h0010, 32'h0,        1, 0, 1, 14'h0010); // BOOT read by M1
    add(1, 1, 14'h0010, 0, 0, 14'h0000, 32'h0,        1, 0, 0, 14'h0000); // boot_done, still BOOT
    add(0, 1, 14'h0010, 0, 0, 14'h0000, 32'h0,        0, 1, 0, 14'h0010); // RUN, M0 fetch
    add(1, 0, 14'h0000, 1, 1, 14'h3FFF, 32'h12345678, 0, 0, 1, 14'h3FFF); // top addr write, bd ignored
    add(0, 0, 14'h0000, 1, 0, 14'h3FFF, 32'h0,        0, 0, 1, 14'h3FFF); // read back top addr
    for (int k = 0; k < 2; k++) begin                                      // contention, two rounds
      for (int j = 0; j < 4; j++)
        add(0, 1, 14'h0010, 1, 0, 14'h3FFF, 32'h0,    0, 0, 1, 14'h3FFF);
      add(0, 1, 14'h0010, 1, 0, 14'h3FFF, 32'h0,      0, 1, 0, 14'h0010);
    end
    add(0, 1, 14'h0010, 0, 0, 14'h0000, 32'h0,        0, 1, 0, 14'h0010); // alternating
    add(0, 0, 14'h0000, 1, 0, 14'h3FFF, 32'h0,        0, 0, 1, 14'h3FFF);
    add(0, 1, 14'h0010, 0, 0, 14'h0000, 32'h0,        0, 1, 0, 14'h0010);
    add(0, 0, 14'h0000, 1, 1, 14'h0020, 32'hA5A55A5A, 0, 0, 1, 14'h0020);
    add(0, 1, 14'h3FFF, 0, 0, 14'h0000, 32'h0,        0, 1, 0, 14'h3FFF);
    add(0, 0, 14'h0000, 1, 0, 14'h0020, 32'h0,        0, 0, 1, 14'h0020);
    add(0, 1, 14'h0020, 0, 0, 14'h0000, 32'h0,        0, 1, 0, 14'h0020);
    add(0, 0, 14'h0000, 1, 0, 14'h0010, 32'h0,        0, 0, 1, 14'h0010);
    add(0, 0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 0, 0, 14'h0000); // drain
    add(0, 0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 0, 0, 14'h0000);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_boot", -1, 32'(in_boot), 32'd1);
    chk("reset_m0_gnt", -1, 32'(m0_gnt), 32'd0);
    chk("reset_rvalid", -1, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

    // Table: each row is one cycle, inputs driven after posedge, outputs sampled at negedge
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      boot_done = tv[i].bd;
      m0_req = tv[i].q0; m0_addr = tv[i].a0;
      m1_req = tv[i].q1; m1_we = tv[i].we; m1_addr = tv[i].a1; m1_wdata = tv[i].wd;
      iss0[i] = tv[i].e_g0;
      iss1[i] = tv[i].e_g1 & ~tv[i].we;
      issd[i] = tv[i].e_g0 ? shadow[tv[i].a0] : shadow[tv[i].a1];
      if (tv[i].e_g1 && tv[i].we) shadow[tv[i].a1] = tv[i].wd;
      @(negedge clk);
      chk("in_boot", i, 32'(in_boot), 32'(tv[i].e_boot));
      chk("m0_gnt", i, 32'(m0_gnt), 32'(tv[i].e_g0));
      chk("m1_gnt", i, 32'(m1_gnt), 32'(tv[i].e_g1));
      chk("ram_addr", i, 32'(ram_addr), 32'(tv[i].e_addr));
      chk("ram_wr_en", i, 32'(ram_wr_en), 32'(tv[i].e_g1 & tv[i].we));
      if (tv[i].e_g1 && tv[i].we) chk("ram_wr_data", i, ram_wr_data, tv[i].wd);
      chk("m0_rvalid", i, 32'(m0_rvalid), 32'((i >= LAT) && iss0[i-LAT]));
      chk("m1_rvalid", i, 32'(m1_rvalid), 32'((i >= LAT) && iss1[i-LAT]));
      if (i >= LAT && iss0[i-LAT]) chk("m0_rdata", i, m0_rdata, issd[i-LAT]);
      if (i >= LAT && iss1[i-LAT]) chk("m1_rdata", i, m1_rdata, issd[i-LAT]);
    end

    // Reset the cycle after an M0 read grant: read is dropped, back in BOOT
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 14'h0010;
    @(negedge clk);
    chk("rst_seq_m0_gnt", 100, 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    chk("rst_seq_rvalid_in_rst", 101, 32'(m0_rvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b1;
    @(negedge clk);
    chk("rst_seq_in_boot", 102, 32'(in_boot), 32'd1);
    chk("rst_seq_m0_gnt_boot", 102, 32'(m0_gnt), 32'd0);
    chk("rst_seq_rvalid", 102, 32'(m0_rvalid), 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("rst_seq_rvalid_late", 103, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
